// File: rtl/nwb_pkg.sv
// rtl/nwb_pkg.sv - FSM state encodings and saturation helpers for neuron_writeback
package nwb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int NWB_DATA_W = 8;

  // Signed saturation limits of a data_w-bit two's-complement neuron value.
  function automatic int sat_max(input int data_w);
    return (1 << (data_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int data_w);
    return -(1 << (data_w - 1));
  endfunction

endpackage

// File: rtl/nwb_fifo.sv
// rtl/nwb_fifo.sv - registered DEPTH x W FIFO with full/empty flags, no bypass path
module nwb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  wr_ptr_q, wr_ptr_d;
  logic [PW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/neuron_writeback.sv
// rtl/neuron_writeback.sv - shift/saturate MAC sums and write them to neuron RAM at layer_base+idx
// Optional ReLU after clamping when NWB_RELU_EN is defined.
module neuron_writeback
  import nwb_pkg::*;
#(
  parameter int ACC_W  = 16,
  parameter int DATA_W = NWB_DATA_W,
  parameter int ADDR_W = 8,
  parameter int SHIFT  = 0,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              layer_start,
  input  logic [ADDR_W-1:0] layer_base,
  input  logic [ADDR_W-1:0] Nk,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              layer_done
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_W));

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] nk_q, nk_d;
  logic [ADDR_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic [DATA_W-1:0] conv;
  logic signed [ACC_W-1:0] shifted;
  logic              push, pop, writing;

  assign shifted = $signed(in_data) >>> SHIFT;

  always_comb begin
    conv = shifted[DATA_W-1:0];
    if (shifted > SAT_HI)      conv = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < SAT_LO) conv = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef NWB_RELU_EN
    if (shifted[ACC_W-1])      conv = '0;
`endif
  end

  assign writing    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign in_ready   = (state_q == ST_RUN) && !fifo_full && (acc_cnt_q < nk_q);
  assign push       = in_valid && in_ready;
  assign wr_en      = writing && !fifo_empty;
  assign pop        = wr_en && wr_ack;
  assign wr_addr    = wr_en ? base_q + wr_cnt_q : '0;
  assign wr_data    = wr_en ? fifo_head : '0;
  assign busy       = (state_q != ST_IDLE);
  assign layer_done = (state_q == ST_DONE);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    nk_d      = nk_q;
    acc_cnt_d = push ? acc_cnt_q + 1'b1 : acc_cnt_q;
    wr_cnt_d  = pop ? wr_cnt_q + 1'b1 : wr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (layer_start) begin
          base_d    = layer_base;
          nk_d      = Nk;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          state_d   = (Nk == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        // Completion takes priority: the last ack can land while still in RUN.
        if (pop && (wr_cnt_q + 1'b1 == nk_q))              state_d = ST_DONE;
        else if (state_q == ST_RUN && acc_cnt_q == nk_q)   state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      nk_q      <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      nk_q      <= nk_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  nwb_fifo #(
    .DEPTH(DEPTH),
    .W    (DATA_W)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (reset),
    .push_i     (push),
    .push_data_i(conv),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_neuron_writeback.sv
// tb/tb_neuron_writeback.sv - randomized bench with queue reference model for neuron_writeback
module tb_neuron_writeback;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       layer_start = 1'b0;
  logic [7:0] layer_base = '0;
  logic [7:0] nk_in = '0;
  logic       in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic       wr_ack = 1'b0;
  logic       in_ready, wr_en, busy, layer_done;
  logic [7:0] wr_addr, wr_data;

  neuron_writeback #(
    .ACC_W(16), .DATA_W(8), .ADDR_W(8), .SHIFT(0), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(rst_n), .layer_start(layer_start), .layer_base(layer_base),
    .Nk(nk_in), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference conversion: integer value, saturate to int8, optional ReLU, 8-bit pattern.
  function automatic int conv(input logic [15:0] d);
    int x;
    x = int'($signed(d));
    if (x > 127)  x = 127;
    if (x < -128) x = -128;
`ifdef NWB_RELU_EN
    if (x < 0) x = 0;
`endif
    return x & 255;
  endfunction

  // Behavioural model: a layer is "active" from the cycle after start until the Nk-th write.
  bit m_active = 0, m_done = 0;
  int m_base, m_nk, m_acc, m_wr;
  int m_q[$];
  bit prev_stall = 0;
  int prev_addr, prev_data;
  int log_addr[$], log_data[$];
  int e_ready, e_wen, e_addr, e_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wr_en", int'(wr_en), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_done", int'(layer_done), 0);
      m_active = 0; m_done = 0; m_q.delete(); prev_stall = 0;
    end else begin
      e_ready = int'(m_active && (m_acc - m_wr) < DEPTH && m_acc < m_nk);
      e_wen   = int'(m_active && m_q.size() > 0);
      e_addr  = e_wen != 0 ? (m_base + m_wr) & 255 : 0;
      e_data  = e_wen != 0 ? m_q[0] : 0;
      chk("in_ready", int'(in_ready), e_ready);
      chk("wr_en", int'(wr_en), e_wen);
      chk("wr_addr", int'(wr_addr), e_addr);
      chk("wr_data", int'(wr_data), e_data);
      chk("busy", int'(busy), int'(m_active || m_done));
      chk("layer_done", int'(layer_done), int'(m_done));
      if (prev_stall) begin
        chk("stall_addr", int'(wr_addr), prev_addr);
        chk("stall_data", int'(wr_data), prev_data);
      end
      prev_stall = wr_en && !wr_ack;
      prev_addr  = int'(wr_addr);
      prev_data  = int'(wr_data);
      if (wr_en && wr_ack) begin
        log_addr.push_back(int'(wr_addr));
        log_data.push_back(int'(wr_data));
      end
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (layer_start) begin
          m_base = int'(layer_base); m_nk = int'(nk_in);
          m_acc = 0; m_wr = 0; m_q.delete();
          if (m_nk == 0) m_done = 1;
          else m_active = 1;
        end
      end else begin
        if (e_wen != 0 && wr_ack) begin
          void'(m_q.pop_front());
          m_wr++;
        end
        if (in_valid && e_ready != 0) begin
          m_q.push_back(conv(in_data));
          m_acc++;
        end
        if (m_wr == m_nk) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
  end

  int vals[$];

  task automatic run_layer(input int b, input int n, input int vprob, input int aprob,
                           input int ack_hold, input int inject, output int done_cyc);
    int idx = 0;
    int cyc = 0;
    bit fire;
    bit seen = 0;
    @(posedge clk); #1;
    layer_start = 1; layer_base = 8'(b); nk_in = 8'(n); in_valid = 0; wr_ack = 0;
    @(posedge clk); #1;
    layer_start = 0;
    done_cyc = -1;
    while (!seen && cyc < 3000) begin
      layer_start = (cyc == inject);
      if (cyc == inject) begin layer_base = 8'h40; nk_in = 8'd7; end
      if (idx < vals.size()) begin
        in_valid = ($urandom % 100) < vprob;
        in_data  = 16'(vals[idx]);
      end else begin
        in_valid = 1;
        in_data  = 16'($urandom);
      end
      wr_ack = (cyc >= ack_hold) && (($urandom % 100) < aprob);
      @(negedge clk);
      fire = in_valid && in_ready;
      if (layer_done) begin seen = 1; done_cyc = cyc; end
      @(posedge clk); #1;
      if (fire) idx++;
      cyc++;
    end
    in_valid = 0; wr_ack = 0; layer_start = 0;
    chk("layer_timeout", int'(seen), 1);
  endtask

  int dc, acks;
  int exp_d[3];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    rst_n = 1;

    // T1: saturation of 5, 200, -300 into base 0x10
    log_addr.delete(); log_data.delete();
    vals = '{5, 200, -300};
    run_layer(8'h10, 3, 100, 100, 0, -1, dc);
    exp_d[0] = 8'h05; exp_d[1] = 8'h7F;
`ifdef NWB_RELU_EN
    exp_d[2] = 8'h00;
`else
    exp_d[2] = 8'h80;
`endif
    chk("t1_count", log_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", log_addr[i], 16 + i);
      chk("t1_data", log_data[i], exp_d[i]);
    end

    // T2: RAM stalls 8 cycles, FIFO fills, order preserved
    log_addr.delete(); log_data.delete();
    vals = '{11, 22, 33, 44, 55, 66};
    run_layer(8'h00, 6, 100, 100, 8, -1, dc);
    chk("t2_count", log_addr.size(), 6);
    for (int i = 0; i < 6; i++) chk("t2_data", log_data[i], 11 * (i + 1));

    // T3: address wrap
    log_addr.delete(); log_data.delete();
    vals = '{1, 2, 3, 4};
    run_layer(8'hFE, 4, 100, 100, 0, -1, dc);
    chk("t3_count", log_addr.size(), 4);
    if (log_addr.size() == 4) begin
      chk("t3_a0", log_addr[0], 8'hFE);
      chk("t3_a1", log_addr[1], 8'hFF);
      chk("t3_a2", log_addr[2], 8'h00);
      chk("t3_a3", log_addr[3], 8'h01);
    end

    // T4: empty layer
    log_addr.delete(); log_data.delete();
    vals.delete();
    run_layer(8'h33, 0, 100, 100, 0, -1, dc);
    chk("t4_done_cycle", dc, 0);
    chk("t4_writes", log_addr.size(), 0);

    // T5: reset after two writes, then a fresh one-neuron layer
    vals = '{1, 2, 3, 4, 5};
    acks = 0;
    @(posedge clk); #1;
    layer_start = 1; layer_base = 8'h30; nk_in = 8'd5;
    @(posedge clk); #1;
    layer_start = 0; wr_ack = 1;
    for (int c = 0; c < 100 && acks < 2; c++) begin
      in_valid = 1; in_data = 16'(vals[acks < 5 ? acks : 0]);
      @(negedge clk);
      if (wr_en && wr_ack) acks++;
      @(posedge clk); #1;
    end
    chk("t5_two_acks", acks, 2);
    rst_n = 0;
    #1;
    chk("t5_rst_wr_en", int'(wr_en), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_addr", int'(wr_addr), 0);
    chk("t5_rst_data", int'(wr_data), 0);
    in_valid = 0; wr_ack = 0;
    @(posedge clk); #1;
    rst_n = 1;
    log_addr.delete(); log_data.delete();
    vals = '{77};
    run_layer(8'h20, 1, 100, 100, 0, -1, dc);
    chk("t5_count", log_addr.size(), 1);
    chk("t5_addr", log_addr.size() > 0 ? log_addr[0] : -1, 8'h20);
    chk("t5_data", log_data.size() > 0 ? log_data[0] : -1, 77);

    // T6: layer_start during RUN is ignored
    log_addr.delete(); log_data.delete();
    vals = '{9, 8, 7, 6, 5};
    run_layer(8'h50, 5, 60, 50, 0, 2, dc);
    chk("t6_count", log_addr.size(), 5);
    for (int i = 0; i < log_addr.size(); i++) chk("t6_addr", log_addr[i], 8'h50 + i);

    // Randomized layers with random valid/ack pressure
    for (int k = 0; k < 8; k++) begin
      int n;
      n = int'($urandom_range(1, 20));
      vals.delete();
      for (int i = 0; i < n + 3; i++) vals.push_back(int'($urandom_range(0, 65535)));
      log_addr.delete(); log_data.delete();
      run_layer(int'($urandom_range(0, 255)), n, 70, 60, 0, -1, dc);
      chk("rand_count", log_addr.size(), n);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
